seg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan driver for DIG_NUM digits.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_hex_decode.sv | 18 +
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment bit positions, the blank code and the hex glyph table.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high {g,f,e,d,c,b,a} glyph for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble + blank + decimal point to an active-high {dp,g..a} code.
// Blanking clears only the glyph; the decimal point always passes.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] code
);

  always_comb begin
    code = SEG_OFF;
    code[SEG_DP] = dp;
    if (!blank) code[SEG_G:SEG_A] = hex7(nib);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan driver with blanking, PWM brightness,
// blink, leading-zero suppression and per-frame input snapshots.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FRE     = 12_000_000,
  parameter int DIG_NUM     = 4,
  parameter int SCAN_HZ     = 750,
  parameter int BLINK_HZ    = 2,
  parameter int BLANK_CYC   = 16,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*DIG_NUM-1:0] data_i,
  input  logic [DIG_NUM-1:0]   dp_i,
  input  logic [DIG_NUM-1:0]   blink_i,
  input  logic                 lz_en_i,
  input  logic [3:0]           bright_i,
  output logic [DIG_NUM-1:0]   dig,
  output logic [7:0]           smg,
  output logic                 frame_o
);

  localparam int SLOT_CYC  = CLK_FRE / (SCAN_HZ * DIG_NUM);
  localparam int PH_CYC    = SLOT_CYC / 16;
  localparam int BLINK_CYC = CLK_FRE / (2 * BLINK_HZ);
  localparam int CW = $clog2(SLOT_CYC);
  localparam int PW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
  localparam int IW = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [DIG_NUM-1:0] DIG_IDLE = {DIG_NUM{DIG_ACT_LOW}};
  localparam logic [7:0] SEG_POL  = {8{SEG_ACT_LOW}};
  localparam logic [7:0] SEG_IDLE = SEG_OFF ^ SEG_POL;

  if (SLOT_CYC % 16 != 0 || BLANK_CYC >= PH_CYC ||
      DIG_NUM < 1 || DIG_NUM > 8) begin : g_bad_cfg
    $error("seg_scan_ctrl: inconsistent timing parameters");
  end

  logic [CW-1:0]        cnt;
  logic [PW-1:0]        ph_cnt;
  logic [3:0]           ph;
  logic [IW-1:0]        idx;
  logic [BW-1:0]        bcnt;
  logic                 blink_ph;
  logic [4*DIG_NUM-1:0] data_snap;
  logic [DIG_NUM-1:0]   dp_snap;
  logic [DIG_NUM-1:0]   blink_snap;
  logic                 lz_snap;
  logic [3:0]           bright_snap;

  logic                 slot_end;
  logic                 frame_start;
  logic                 ph_end;
  logic                 lit;
  logic [3:0]           nibs [DIG_NUM];
  logic [DIG_NUM-1:0]   lz_mask;
  logic [DIG_NUM-1:0]   sel;
  logic [7:0]           code;

  assign slot_end    = cnt == CW'(SLOT_CYC - 1);
  assign frame_start = slot_end && idx == IW'(DIG_NUM - 1);
  assign ph_end      = ph_cnt == PW'(PH_CYC - 1);
  assign sel         = DIG_NUM'(1) << idx;

  assign lit = cnt >= CW'(BLANK_CYC) && ph <= bright_snap &&
               !(blink_snap[idx] && blink_ph);

  // A digit is suppressed while every nibble from the left up to it is zero
  always_comb begin
    logic zrun;
    zrun    = lz_snap;
    lz_mask = '0;
    for (int k = 0; k < DIG_NUM; k++) begin
      nibs[k] = data_snap[4*(DIG_NUM-k)-1 -: 4];
      zrun    = zrun && nibs[k] == 4'h0;
      if (k < DIG_NUM - 1) lz_mask[k] = zrun;
    end
  end

  seg_hex_decode u_dec (
    .nib   (nibs[idx]),
    .blank (lz_mask[idx]),
    .dp    (dp_snap[idx]),
    .code  (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      ph_cnt      <= '0;
      ph          <= '0;
      idx         <= '0;
      bcnt        <= '0;
      blink_ph    <= 1'b0;
      data_snap   <= '0;
      dp_snap     <= '0;
      blink_snap  <= '0;
      lz_snap     <= 1'b0;
      bright_snap <= 4'hF;
      frame_o     <= 1'b0;
      dig         <= DIG_IDLE;
      smg         <= SEG_IDLE;
    end else begin
      if (bcnt == BW'(BLINK_CYC - 1)) begin
        bcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        bcnt <= bcnt + 1'b1;
      end

      if (slot_end) begin
        cnt    <= '0;
        ph_cnt <= '0;
        ph     <= '0;
        idx    <= (idx == IW'(DIG_NUM - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (ph_end) begin
          ph_cnt <= '0;
          ph     <= ph + 1'b1;
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
        end
      end

      if (cnt == '0) bright_snap <= bright_i;

      // Whole-frame capture keeps a multi-digit value from tearing
      if (frame_start) begin
        data_snap  <= data_i;
        dp_snap    <= dp_i;
        blink_snap <= blink_i;
        lz_snap    <= lz_en_i;
      end

      frame_o <= frame_start;
      dig     <= lit ? (sel ^ DIG_IDLE) : DIG_IDLE;
      smg     <= lit ? (code ^ SEG_POL) : SEG_IDLE;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-frame expected lit runs
// are queued from a reference model and matched by a run monitor.
module tb_seg_scan_ctrl;

  localparam int SLOT  = 64;
  localparam int FRAME = 256;
  localparam int BLINK = 16000;
  localparam int NFR   = 140;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic        lz;
    logic [3:0]  bright;
  } set_t;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] smg;
    int         len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic [3:0]  blink_i;
  logic        lz_en_i;
  logic [3:0]  bright_i;
  logic [3:0]  dig;
  logic [7:0]  smg;
  logic        frame_o;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .CLK_FRE     (64000),
    .DIG_NUM     (4),
    .SCAN_HZ     (250),
    .BLINK_HZ    (2),
    .BLANK_CYC   (2),
    .DIG_ACT_LOW (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .dp_i     (dp_i),
    .blink_i  (blink_i),
    .lz_en_i  (lz_en_i),
    .bright_i (bright_i),
    .dig      (dig),
    .smg      (smg),
    .frame_o  (frame_o)
  );

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_f = 0;
  bit   mon_en = 1'b0;

  set_t dir [6] = '{
    '{16'h1234, 4'h0, 4'h0, 1'b0, 4'd15},
    '{16'h1234, 4'h0, 4'h0, 1'b0, 4'd0},
    '{16'h0005, 4'b0100, 4'h0, 1'b1, 4'd7},
    '{16'h0000, 4'h0, 4'h0, 1'b1, 4'd15},
    '{16'h1234, 4'h0, 4'b0001, 1'b0, 4'd15},
    '{16'h1234, 4'h0, 4'b0001, 1'b0, 4'd15}};

  // Cycles elapsed since the last reset, counted in scan-state cycles
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected lit runs for one frame whose first slot starts at cycle f
  task automatic push_frame(input set_t s, input logic [3:0] b, input int f);
    exp_t       e;
    logic [3:0] one;
    logic [3:0] nib;
    bit         blank;
    int         bph;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      nib   = s.data[15-4*k -: 4];
      blank = s.lz && k < 3 && (s.data >> (4 * (3 - k))) == 16'h0;
      bph   = ((f + SLOT * k) / BLINK) % 2;
      if (!(s.blink[k] && bph == 1)) begin
        e.dig = ~(one << k);
        e.smg = ~{s.dp[k], blank ? 7'h00 : HEX[nib]};
        e.len = 4 * (int'(b) + 1) - 2;
        q.push_back(e);
      end
    end
  endtask

  function automatic set_t rand_set();
    set_t s;
    s.data   = 16'($urandom) >> (4 * $urandom_range(0, 4));
    s.dp     = 4'($urandom);
    s.blink  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    s.lz     = 1'($urandom);
    s.bright = 4'($urandom);
    return s;
  endfunction

  task automatic drive_data(input set_t s);
    data_i  = s.data;
    dp_i    = s.dp;
    blink_i = s.blink;
    lz_en_i = s.lz;
  endtask

  task automatic check_reset();
    n_chk++;
    if (dig !== 4'hF || smg !== 8'hFF || frame_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: dig=%h smg=%h frame_o=%b want F FF 0",
               dig, smg, frame_o);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_o !== 1'b1 && n < 600);
    n_chk++;
    if (frame_o !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_timeout: no frame_o within %0d cycles", n);
    end else if (cyc - last_f != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d want %0d", cyc - last_f, FRAME);
    end
    last_f = cyc;
  endtask

  task automatic flush();
    wait_frame();
    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_runs: %0d expected runs never seen", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic run_frames(input int nfr, input bit use_dir,
                            inout set_t prev);
    set_t s;
    set_t s2;
    for (int n = 0; n < nfr; n++) begin
      wait_frame();
      s = (use_dir && n < 6) ? dir[n] : rand_set();
      drive_data(s);
      bright_i = s.bright;
      push_frame(prev, s.bright, cyc);
      if (use_dir && n < 6) begin
        prev = s;
      end else begin
        repeat (100) @(negedge clk);
        s2 = rand_set();
        drive_data(s2);
        prev = s2;
      end
    end
  endtask

  // Run monitor: each contiguous lit period is one scoreboard item
  initial begin
    logic [3:0] r_dig;
    logic [7:0] r_smg;
    int         r_len;
    bit         in_run;
    exp_t       e;
    in_run = 1'b0;
    r_dig  = 4'hF;
    r_smg  = 8'hFF;
    r_len  = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        in_run = 1'b0;
      end else begin
        n_chk++;
        if ($countones(~dig) > 1) begin
          n_fail++;
          $display("FAIL one_hot: dig=%b", dig);
        end
        if (in_run && dig == r_dig && smg == r_smg) begin
          r_len++;
        end else begin
          if (in_run) begin
            n_chk++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_run: dig=%b smg=%h len=%0d",
                       r_dig, r_smg, r_len);
            end else begin
              e = q.pop_front();
              if (r_dig !== e.dig || r_smg !== e.smg || r_len != e.len) begin
                n_fail++;
                $display("FAIL run: got dig=%b smg=%h len=%0d want dig=%b smg=%h len=%0d",
                         r_dig, r_smg, r_len, e.dig, e.smg, e.len);
              end
            end
          end
          in_run = 1'b0;
          if (dig != 4'hF) begin
            in_run = 1'b1;
            r_dig  = dig;
            r_smg  = smg;
            r_len  = 1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_t prev;
    set_t zero;
    zero     = '0;
    rst      = 1'b1;
    data_i   = 16'h1234;
    dp_i     = 4'h0;
    blink_i  = 4'h0;
    lz_en_i  = 1'b0;
    bright_i = 4'd15;
    prev     = '{16'h1234, 4'h0, 4'h0, 1'b0, 4'd15};

    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check_reset();
    end
    push_frame(zero, bright_i, 0);
    mon_en = 1'b1;
    last_f = 0;
    rst    = 1'b0;

    run_frames(NFR, 1'b1, prev);
    flush();

    repeat (100) @(negedge clk);
    q.delete();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset();
    end
    push_frame(zero, bright_i, 0);
    mon_en = 1'b1;
    last_f = 0;
    rst    = 1'b0;

    run_frames(4, 1'b0, prev);
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
